hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal range 1..7: number of cycles PR1 is flushed after a taken branch.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have inputs IFID_rs, IFID_rt (3 each) and IFID_uses_rt (1): decode-stage sources and rt-use flag.
REQ-005 SHALL have inputs PR2_RF_write_en, PR2_MEM_read (1 each) and PR2_rd (3): instruction in the ID/EX register.
REQ-006 SHALL have inputs branch_taken (1) and mem_busy (1, memory not ready, pipeline freezes).
REQ-007 SHALL have outputs PC_write_en, PR1_write_en, PR2_write_en, PR1_flush, PR2_flush (1 each) and hazard_state (2).
REQ-008 SHALL, with HAZARD_STATS_EN defined, add outputs stall_count (16) and flush_count (16).

Function
REQ-009 SHALL encode states RUN=0, FLUSH=1, MEM_WAIT=2; code 3 SHALL behave as RUN and go to RUN next cycle; hazard_state = current state.
REQ-010 SHALL hold a 3-bit flush counter fcnt and a pending-branch bit pend_br.
REQ-011 SHALL drive outputs combinationally from state, fcnt, pend_br and current inputs; defaults: all write_en=1, all flush=0.
REQ-012 SHALL define load_use = PR2_MEM_read & PR2_RF_write_en & PR2_rd!=0 & (PR2_rd==IFID_rs | (IFID_uses_rt & PR2_rd==IFID_rt)).
REQ-013 RUN priority: mem_busy > branch_taken > load_use.
REQ-014 RUN, mem_busy=1: PC/PR1/PR2_write_en=0, flushes 0; next MEM_WAIT; pend_br set if branch_taken=1 same cycle.
REQ-015 RUN, branch_taken=1, mem_busy=0: PR1_flush=PR2_flush=1; FLUSH_CYCLES=1 -> stay RUN; else fcnt<=FLUSH_CYCLES-1, next FLUSH.
REQ-016 RUN, load_use only: PC_write_en=0, PR1_write_en=0, PR2_flush=1; stay RUN (exactly one bubble; load then forwards from PR4).
REQ-017 FLUSH, mem_busy=0: PR1_flush=1, PR2_flush=0, fcnt decrements; fcnt==1 -> RUN; branch_taken and load_use ignored.
REQ-018 FLUSH, mem_busy=1: freeze as REQ-014, fcnt held, next MEM_WAIT.
REQ-019 MEM_WAIT, mem_busy=1: freeze; branch_taken sets pend_br; fcnt held.
REQ-020 MEM_WAIT, mem_busy=0: pend_br=1 -> act as REQ-015 with pend_br cleared; else fcnt!=0 -> act as FLUSH; else act as RUN (load_use evaluated).
REQ-021 pend_br SHALL never be set while branch flush is already applied in the same cycle; at most one pending branch retained.

Reset
REQ-022 rst=1 at a rising edge SHALL force state=RUN, fcnt=0, pend_br=0, counters=0, overriding all inputs, including mid-FLUSH or mid-MEM_WAIT.
REQ-023 Outputs during reset-cycle SHALL follow RUN decode of current inputs; first post-reset cycle SHALL be RUN with defaults absent hazards.

Configuration
REQ-024 Macro HAZARD_STATS_EN defined: stall_count +1 each cycle PC_write_en=0, flush_count +1 each cycle REQ-015 fires; both saturate at 16'hFFFF.
REQ-025 Macro HAZARD_STATS_EN undefined: counter ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-026 PR2 load rd=3, IFID_rs=3 -> one cycle PC_write_en=0, PR1_write_en=0, PR2_flush=1, then defaults; rd=0 same case -> no stall.
REQ-027 FLUSH_CYCLES=3, branch_taken pulse -> cycle0 PR1_flush=PR2_flush=1, cycles1-2 PR1_flush only, state 0->1->1->0.
REQ-028 mem_busy high 4 cycles with branch_taken pulse in cycle2 -> 4 freeze cycles, then branch flush on first cycle mem_busy=0.
REQ-029 branch_taken and load_use together -> flush only, no PC stall; mem_busy with both -> freeze, pend_br=1.
REQ-030 rst asserted in FLUSH (fcnt=2) -> next cycle state=RUN, PR1_flush=0.
REQ-031 HAZARD_STATS_EN, 70000 consecutive mem_busy cycles -> stall_count=16'hFFFF, held.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller. Detects load-use hazards against the ID/EX
//   register, flushes the front end after a taken branch, and freezes the
//   whole pipeline while memory is busy. A branch seen while frozen is
//   remembered and its flush is applied on the first unfrozen cycle.
//
//   Parameter FLUSH_CYCLES (1..7): cycles PR1 is flushed after a taken branch.
//   Optional macro HAZARD_STATS_EN adds saturating stall/flush counters.
//
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     IFID_rs, IFID_rt, IFID_uses_rt  decode-stage sources
//     PR2_RF_write_en, PR2_MEM_read,
//     PR2_rd                          instruction held in ID/EX
//     branch_taken, mem_busy          redirect request, memory not ready
//     PC/PR1/PR2_write_en             register enables (combinational)
//     PR1_flush, PR2_flush            bubble insertion (combinational)
//     hazard_state                    current controller state
//     stall_count, flush_count        statistics (HAZARD_STATS_EN only)
module hazard_control_unit #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  IFID_rs,
    input  logic [2:0]  IFID_rt,
    input  logic        IFID_uses_rt,
    input  logic        PR2_RF_write_en,
    input  logic        PR2_MEM_read,
    input  logic [2:0]  PR2_rd,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        PC_write_en,
    output logic        PR1_write_en,
    output logic        PR2_write_en,
    output logic        PR1_flush,
    output logic        PR2_flush,
    output logic [1:0]  hazard_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    localparam int unsigned FCNT_W = 3;
    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RSVD     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               pend_br_q, pend_br_d;

    logic load_use;
    logic eval_run, freeze, capture_br, take_branch, step_flush, stall;

    // Load in ID/EX whose destination is read by the instruction in decode.
    assign load_use = PR2_MEM_read & PR2_RF_write_en & (PR2_rd != 3'd0) &
                      ((PR2_rd == IFID_rs) | (IFID_uses_rt & (PR2_rd == IFID_rt)));

    assign hazard_state = state_q;

    // Action selection, then output/next-state decode from the chosen action.
    always_comb begin
        eval_run     = rst;
        freeze       = 1'b0;
        capture_br   = 1'b0;
        take_branch  = 1'b0;
        step_flush   = 1'b0;
        stall        = 1'b0;
        PC_write_en  = 1'b1;
        PR1_write_en = 1'b1;
        PR2_write_en = 1'b1;
        PR1_flush    = 1'b0;
        PR2_flush    = 1'b0;
        state_d      = ST_RUN;
        fcnt_d       = fcnt_q;
        pend_br_d    = pend_br_q;

        // Branch/load-use of the flushed slot are meaningless during FLUSH.
        if (!rst) begin
            case (state_q)
                ST_FLUSH: begin
                    if (mem_busy) freeze = 1'b1;
                    else          step_flush = 1'b1;
                end
                ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        freeze     = 1'b1;
                        capture_br = branch_taken;
                    end else if (pend_br_q) begin
                        take_branch = 1'b1;
                    end else if (fcnt_q != '0) begin
                        step_flush = 1'b1;
                    end else begin
                        eval_run = 1'b1;
                    end
                end
                default: eval_run = 1'b1;
            endcase
        end

        if (eval_run) begin
            if (mem_busy) begin
                freeze     = 1'b1;
                capture_br = branch_taken;
            end else if (branch_taken) begin
                take_branch = 1'b1;
            end else if (load_use) begin
                stall = 1'b1;
            end
        end

        if (freeze) begin
            PC_write_en  = 1'b0;
            PR1_write_en = 1'b0;
            PR2_write_en = 1'b0;
            state_d      = ST_MEM_WAIT;
            pend_br_d    = pend_br_q | capture_br;
        end

        if (take_branch) begin
            PR1_flush = 1'b1;
            PR2_flush = 1'b1;
            pend_br_d = 1'b0;
            if (FLUSH_CYCLES <= 1) begin
                fcnt_d  = '0;
                state_d = ST_RUN;
            end else begin
                fcnt_d  = FCNT_RELOAD;
                state_d = ST_FLUSH;
            end
        end

        if (step_flush) begin
            PR1_flush = 1'b1;
            if (fcnt_q <= FCNT_W'(1)) begin
                fcnt_d  = '0;
                state_d = ST_RUN;
            end else begin
                fcnt_d  = fcnt_q - FCNT_W'(1);
                state_d = ST_FLUSH;
            end
        end

        if (stall) begin
            PC_write_en  = 1'b0;
            PR1_write_en = 1'b0;
            PR2_flush    = 1'b1;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            fcnt_q    <= '0;
            pend_br_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            pend_br_q <= pend_br_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating event counters.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!PC_write_en && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
        if (take_branch && (flush_count_q != 16'hFFFF))
            flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit built with FLUSH_CYCLES=3.
// Observed vector: {hazard_state, PC_we, PR1_we, PR2_we, PR1_flush, PR2_flush}.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  IFID_rs, IFID_rt, PR2_rd;
    logic        IFID_uses_rt, PR2_RF_write_en, PR2_MEM_read;
    logic        branch_taken, mem_busy;
    logic        PC_write_en, PR1_write_en, PR2_write_en, PR1_flush, PR2_flush;
    logic [1:0]  hazard_state;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif

    int checks = 0;
    int errors = 0;

    // {state, pc, pr1, pr2, pr1_flush, pr2_flush}
    localparam logic [4:0] O_DEF    = 5'b11100;
    localparam logic [4:0] O_STALL  = 5'b00101;
    localparam logic [4:0] O_BRANCH = 5'b11111;
    localparam logic [4:0] O_PR1FL  = 5'b11110;
    localparam logic [4:0] O_FREEZE = 5'b00000;

    hazard_control_unit #(.FLUSH_CYCLES(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .IFID_rs         (IFID_rs),
        .IFID_rt         (IFID_rt),
        .IFID_uses_rt    (IFID_uses_rt),
        .PR2_RF_write_en (PR2_RF_write_en),
        .PR2_MEM_read    (PR2_MEM_read),
        .PR2_rd          (PR2_rd),
        .branch_taken    (branch_taken),
        .mem_busy        (mem_busy),
        .PC_write_en     (PC_write_en),
        .PR1_write_en    (PR1_write_en),
        .PR2_write_en    (PR2_write_en),
        .PR1_flush       (PR1_flush),
        .PR2_flush       (PR2_flush),
        .hazard_state    (hazard_state)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [2:0] rs, input logic [2:0] rt, input logic urt,
                          input logic we, input logic mr, input logic [2:0] rd,
                          input logic bt, input logic mb);
        IFID_rs = rs; IFID_rt = rt; IFID_uses_rt = urt;
        PR2_RF_write_en = we; PR2_MEM_read = mr; PR2_rd = rd;
        branch_taken = bt; mem_busy = mb;
    endtask

    task automatic idle();
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // Settle combinational outputs, compare, then advance one clock.
    task automatic step(input string tag, input logic [1:0] st, input logic [4:0] o);
        logic [6:0] got, exp;
        #1;
        got = {hazard_state, PC_write_en, PR1_write_en, PR2_write_en, PR1_flush, PR2_flush};
        exp = {st, o};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        // Reset held: RUN decode of current inputs
        step("reset_idle", 2'd0, O_DEF);
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        step("reset_loaduse_decode", 2'd0, O_STALL);
        rst = 1'b0;
        idle();
        step("post_reset_idle", 2'd0, O_DEF);

        // Load-use: one bubble, then defaults
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        step("lu_rs", 2'd0, O_STALL);
        idle();
        step("lu_after", 2'd0, O_DEF);
        set_in(3'd1, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        step("lu_rt", 2'd0, O_STALL);
        set_in(3'd1, 3'd5, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        step("lu_rt_unused", 2'd0, O_DEF);
        set_in(3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        step("lu_rd0", 2'd0, O_DEF);
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
        step("lu_not_load", 2'd0, O_DEF);

        // Branch pulse with 3 flush cycles; load-use in FLUSH ignored
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        step("br_c0", 2'd0, O_BRANCH);
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        step("br_c1", 2'd1, O_PR1FL);
        idle();
        step("br_c2", 2'd1, O_PR1FL);
        step("br_done", 2'd0, O_DEF);

        // Branch and load-use together: flush only
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        step("br_lu_c0", 2'd0, O_BRANCH);
        idle();
        step("br_lu_c1", 2'd1, O_PR1FL);
        step("br_lu_c2", 2'd1, O_PR1FL);
        step("br_lu_done", 2'd0, O_DEF);

        // mem_busy 4 cycles, branch pulse in the third
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        step("mb_c0", 2'd0, O_FREEZE);
        step("mb_c1", 2'd2, O_FREEZE);
        branch_taken = 1'b1;
        step("mb_c2_br", 2'd2, O_FREEZE);
        branch_taken = 1'b0;
        step("mb_c3", 2'd2, O_FREEZE);
        idle();
        step("mb_pend_flush", 2'd2, O_BRANCH);
        step("mb_fl1", 2'd1, O_PR1FL);
        step("mb_fl2", 2'd1, O_PR1FL);
        step("mb_done", 2'd0, O_DEF);

        // mem_busy with branch and load-use: freeze, branch retained
        set_in(3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
        step("mb_br_lu", 2'd0, O_FREEZE);
        idle();
        step("mb_br_lu_pend", 2'd2, O_BRANCH);
        step("mb_br_lu_fl1", 2'd1, O_PR1FL);
        step("mb_br_lu_fl2", 2'd1, O_PR1FL);
        step("mb_br_lu_done", 2'd0, O_DEF);

        // mem_busy during FLUSH holds the flush count
        branch_taken = 1'b1;
        step("flmb_br", 2'd0, O_BRANCH);
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        step("flmb_freeze", 2'd1, O_FREEZE);
        idle();
        step("flmb_resume1", 2'd2, O_PR1FL);
        step("flmb_resume2", 2'd1, O_PR1FL);
        step("flmb_done", 2'd0, O_DEF);

        // Reset mid-FLUSH with two flush cycles left
        branch_taken = 1'b1;
        step("rstfl_br", 2'd0, O_BRANCH);
        idle();
        rst = 1'b1;
        step("rstfl_during", 2'd1, O_DEF);
        rst = 1'b0;
        step("rstfl_after", 2'd0, O_DEF);
        step("rstfl_after2", 2'd0, O_DEF);

`ifdef HAZARD_STATS_EN
        checks++;
        assert (flush_count === 16'd0) else begin
            errors++;
            $error("FAIL flush_cnt_reset observed=%h expected=0000", flush_count);
        end
        mem_busy = 1'b1;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        checks++;
        assert (stall_count === 16'hFFFF) else begin
            errors++;
            $error("FAIL stall_sat observed=%h expected=ffff", stall_count);
        end
        @(posedge clk);
        #1;
        checks++;
        assert (stall_count === 16'hFFFF) else begin
            errors++;
            $error("FAIL stall_sat_hold observed=%h expected=ffff", stall_count);
        end
        mem_busy = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
